// File: rtl/nandy_sequencer.sv
// Instruction sequencer for the Nandy core: owns the IR and the phase bit.
// It also handles the fetch handshake, data-memory stall, interrupt injection and halt.
module nandy_sequencer #(
    parameter logic [7:0] INT_OPCODE = 8'h14,
    parameter bit         IRQ_EN     = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] inst_in,
    input  logic       inst_valid,
    input  logic       mem_ready,
    input  logic       irq,
    input  logic       cli,
    input  logic       halt_req,
    output logic [7:0] inst,
    output logic       cycle,
    output logic       fetch_req,
    output logic       pc_inc,
    output logic       commit,
    output logic       int_take,
    output logic       int_active,
    output logic       halted
);

    typedef enum logic [2:0] {
        RESET = 3'd0,
        FETCH = 3'd1,
        EXEC0 = 3'd2,
        EXEC1 = 3'd3,
        HALT  = 3'd4
    } stateType;

    stateType   stateReg, stateNext;
    logic [7:0] instReg, instNext;
    logic       intActiveReg, intActiveNext;
    logic       pcIncReg, pcIncNext;
    logic       intTakeReg, intTakeNext;

    logic       irqTake;
    logic       memStall;

    assign irqTake  = IRQ_EN && irq && !intActiveReg;
    assign memStall = (instReg[7:6] == 2'b10) && !mem_ready;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateReg     <= RESET;
            instReg      <= 8'h00;
            intActiveReg <= 1'b0;
            pcIncReg     <= 1'b0;
            intTakeReg   <= 1'b0;
        end else begin
            stateReg     <= stateNext;
            instReg      <= instNext;
            intActiveReg <= intActiveNext;
            pcIncReg     <= pcIncNext;
            intTakeReg   <= intTakeNext;
        end
    end

    // Next-state logic. pc_inc and int_take are registered, so they pulse
    // during the first EXEC0 clock that follows the accepting FETCH edge.
    always_comb begin
        stateNext     = stateReg;
        instNext      = instReg;
        intActiveNext = intActiveReg;
        pcIncNext     = 1'b0;
        intTakeNext   = 1'b0;
        case (stateReg)
            RESET: stateNext = FETCH;
            FETCH: begin
                if (irqTake) begin
                    instNext      = INT_OPCODE;
                    intTakeNext   = 1'b1;
                    intActiveNext = 1'b1;
                    stateNext     = EXEC0;
                end else if (inst_valid) begin
                    instNext  = inst_in;
                    pcIncNext = 1'b1;
                    stateNext = EXEC0;
                end
            end
            EXEC0: begin
                if (cli) begin
                    intActiveNext = 1'b0;
                end
                if (instReg[7]) begin
                    stateNext = EXEC1;
                end else if (halt_req) begin
                    stateNext = HALT;
                end else begin
                    stateNext = FETCH;
                end
            end
            EXEC1: begin
                if (!memStall) begin
                    stateNext = FETCH;
                end
            end
            HALT: begin
                if (irqTake) begin
                    stateNext = FETCH;
                end
            end
            default: stateNext = RESET;
        endcase
    end

    // Outputs. The EXEC1 commit is qualified by the memory ack in the same
    // clock so the write lands on the edge that ends the stall.
    always_comb begin
        inst       = instReg;
        int_active = intActiveReg;
        pc_inc     = pcIncReg;
        int_take   = intTakeReg;
        fetch_req  = (stateReg == FETCH);
        cycle      = (stateReg == EXEC1);
        halted     = (stateReg == HALT);
        commit     = (stateReg == EXEC0) || ((stateReg == EXEC1) && !memStall);
    end

endmodule

// File: tb/tb_nandy_sequencer.sv
// Self-checking bench for nandy_sequencer: inline per-scenario checks plus
// a commit scoreboard of {inst, cycle} for every committed phase.
module tb_nandy_sequencer;

    logic       clk;
    logic       rst_n;
    logic [7:0] inst_in;
    logic       inst_valid;
    logic       mem_ready;
    logic       irq;
    logic       cli;
    logic       halt_req;
    logic [7:0] inst;
    logic       cycle;
    logic       fetch_req;
    logic       pc_inc;
    logic       commit;
    logic       int_take;
    logic       int_active;
    logic       halted;

    int errors = 0;
    int checks = 0;

    logic [8:0] expQ[$];
    logic [8:0] obsQ[$];

    nandy_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .inst_in    (inst_in),
        .inst_valid (inst_valid),
        .mem_ready  (mem_ready),
        .irq        (irq),
        .cli        (cli),
        .halt_req   (halt_req),
        .inst       (inst),
        .cycle      (cycle),
        .fetch_req  (fetch_req),
        .pc_inc     (pc_inc),
        .commit     (commit),
        .int_take   (int_take),
        .int_active (int_active),
        .halted     (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Commit monitor: every committed phase is logged for the scoreboard
    always @(negedge clk) begin
        if (commit === 1'b1) begin
            obsQ.push_back({inst, cycle});
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({inst, cycle, int_active, fetch_req, pc_inc, commit, int_take, halted} !== 15'h0) begin
            errors++;
            $display("FAIL reset_values: got %h expected %h",
                     {inst, cycle, int_active, fetch_req, pc_inc, commit, int_take, halted}, 15'h0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (fetch_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: fetch_req got %b expected 0", fetch_req);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (fetch_req !== 1'b1) begin
            errors++;
            $display("FAIL reset_to_fetch: fetch_req got %b expected 1", fetch_req);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        inst_in    = 8'h48;
        inst_valid = 1'b1;
        expQ.push_back({8'h48, 1'b0});
        @(negedge clk);
        checks++;
        if ({fetch_req, pc_inc} !== 2'b10) begin
            errors++;
            $display("FAIL single_fetch: fetch_req,pc_inc got %b expected 10", {fetch_req, pc_inc});
        end
        @(posedge clk); #1;
        inst_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({inst, cycle, commit, pc_inc} !== {8'h48, 1'b0, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL single_exec0: inst,cycle,commit,pc_inc got %h expected %h",
                     {inst, cycle, commit, pc_inc}, {8'h48, 1'b0, 1'b1, 1'b1});
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if ({fetch_req, commit} !== 2'b10) begin
            errors++;
            $display("FAIL single_refetch: fetch_req,commit got %b expected 10", {fetch_req, commit});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_mem_stall();
        inst_in    = 8'h85;
        inst_valid = 1'b1;
        mem_ready  = 1'b0;
        expQ.push_back({8'h85, 1'b0});
        expQ.push_back({8'h85, 1'b1});
        @(posedge clk); #1;
        inst_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({inst, cycle, commit} !== {8'h85, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL stall_exec0: inst,cycle,commit got %h expected %h",
                     {inst, cycle, commit}, {8'h85, 1'b0, 1'b1});
        end
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++) begin
            mem_ready = (k == 3);
            @(negedge clk);
            checks++;
            if ({cycle, commit} !== {1'b1, (k == 3)}) begin
                errors++;
                $display("FAIL stall_exec1[%0d]: cycle,commit got %b expected %b",
                         k, {cycle, commit}, {1'b1, (k == 3)});
            end
            @(posedge clk); #1;
        end
        mem_ready = 1'b0;
        @(negedge clk);
        checks++;
        if ({fetch_req, cycle} !== 2'b10) begin
            errors++;
            $display("FAIL stall_exit: fetch_req,cycle got %b expected 10", {fetch_req, cycle});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_jump();
        halt_req   = 1'b1;
        mem_ready  = 1'b0;
        inst_in    = 8'hE0;
        inst_valid = 1'b1;
        expQ.push_back({8'hE0, 1'b0});
        expQ.push_back({8'hE0, 1'b1});
        @(posedge clk); #1;
        inst_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({inst, cycle, commit} !== {8'hE0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL jump_exec0: inst,cycle,commit got %h expected %h",
                     {inst, cycle, commit}, {8'hE0, 1'b0, 1'b1});
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if ({cycle, commit} !== 2'b11) begin
            errors++;
            $display("FAIL jump_exec1: cycle,commit got %b expected 11", {cycle, commit});
        end
        @(posedge clk); #1;
        halt_req = 1'b0;
        @(negedge clk);
        checks++;
        if ({fetch_req, halted} !== 2'b10) begin
            errors++;
            $display("FAIL jump_no_halt: fetch_req,halted got %b expected 10", {fetch_req, halted});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_interrupt();
        irq        = 1'b1;
        inst_valid = 1'b1;
        inst_in    = 8'h48;
        expQ.push_back({8'h14, 1'b0});
        @(posedge clk); #1;
        inst_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({inst, int_take, pc_inc, int_active, commit} !== {8'h14, 4'b1011}) begin
            errors++;
            $display("FAIL int_entry: inst,int_take,pc_inc,int_active,commit got %h expected %h",
                     {inst, int_take, pc_inc, int_active, commit}, {8'h14, 4'b1011});
        end
        @(posedge clk); #1;
        inst_valid = 1'b1;
        inst_in    = 8'h48;
        expQ.push_back({8'h48, 1'b0});
        @(posedge clk); #1;
        inst_valid = 1'b0;
        cli        = 1'b1;
        @(negedge clk);
        checks++;
        if ({inst, int_take, pc_inc, int_active} !== {8'h48, 3'b011}) begin
            errors++;
            $display("FAIL int_masked: inst,int_take,pc_inc,int_active got %h expected %h",
                     {inst, int_take, pc_inc, int_active}, {8'h48, 3'b011});
        end
        @(posedge clk); #1;
        cli = 1'b0;
        @(negedge clk);
        checks++;
        if ({fetch_req, int_active} !== 2'b10) begin
            errors++;
            $display("FAIL int_cli_clear: fetch_req,int_active got %b expected 10", {fetch_req, int_active});
        end
        expQ.push_back({8'h14, 1'b0});
        @(posedge clk); #1;
        irq = 1'b0;
        cli = 1'b1;
        @(negedge clk);
        checks++;
        if ({inst, int_take, int_active} !== {8'h14, 2'b11}) begin
            errors++;
            $display("FAIL int_reentry: inst,int_take,int_active got %h expected %h",
                     {inst, int_take, int_active}, {8'h14, 2'b11});
        end
        @(posedge clk); #1;
        cli = 1'b0;
        @(negedge clk);
        checks++;
        if (int_active !== 1'b0) begin
            errors++;
            $display("FAIL int_exit: int_active got %b expected 0", int_active);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_halt();
        inst_in    = 8'h1B;
        inst_valid = 1'b1;
        expQ.push_back({8'h1B, 1'b0});
        @(posedge clk); #1;
        inst_valid = 1'b0;
        halt_req   = 1'b1;
        @(negedge clk);
        checks++;
        if ({inst, commit} !== {8'h1B, 1'b1}) begin
            errors++;
            $display("FAIL halt_exec0: inst,commit got %h expected %h", {inst, commit}, {8'h1B, 1'b1});
        end
        @(posedge clk); #1;
        halt_req = 1'b0;
        for (int i = 0; i < 10; i++) begin
            inst_valid = (i % 2 == 1);
            @(negedge clk);
            checks++;
            if ({halted, fetch_req, commit} !== 3'b100) begin
                errors++;
                $display("FAIL halt_hold[%0d]: halted,fetch_req,commit got %b expected 100",
                         i, {halted, fetch_req, commit});
            end
            @(posedge clk); #1;
        end
        inst_valid = 1'b0;
        irq        = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if ({fetch_req, halted} !== 2'b10) begin
            errors++;
            $display("FAIL halt_wake: fetch_req,halted got %b expected 10", {fetch_req, halted});
        end
        expQ.push_back({8'h14, 1'b0});
        @(posedge clk); #1;
        irq = 1'b0;
        cli = 1'b1;
        @(negedge clk);
        checks++;
        if ({inst, int_take, int_active} !== {8'h14, 2'b11}) begin
            errors++;
            $display("FAIL halt_int_take: inst,int_take,int_active got %h expected %h",
                     {inst, int_take, int_active}, {8'h14, 2'b11});
        end
        @(posedge clk); #1;
        cli = 1'b0;
    endtask

    task automatic test_reset_mid_stall();
        irq = 1'b1;
        expQ.push_back({8'h14, 1'b0});
        @(posedge clk); #1;
        irq = 1'b0;
        @(posedge clk); #1;
        inst_in    = 8'h85;
        inst_valid = 1'b1;
        mem_ready  = 1'b0;
        expQ.push_back({8'h85, 1'b0});
        @(posedge clk); #1;
        inst_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if ({cycle, commit, int_active} !== 3'b101) begin
            errors++;
            $display("FAIL rst_pre_stall: cycle,commit,int_active got %b expected 101",
                     {cycle, commit, int_active});
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({inst, cycle, int_active, commit, fetch_req} !== 12'h0) begin
            errors++;
            $display("FAIL rst_async: inst,cycle,int_active,commit,fetch_req got %h expected %h",
                     {inst, cycle, int_active, commit, fetch_req}, 12'h0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if ({fetch_req, inst} !== {1'b1, 8'h00}) begin
            errors++;
            $display("FAIL rst_recover: fetch_req,inst got %h expected %h", {fetch_req, inst}, {1'b1, 8'h00});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_scoreboard();
        logic [8:0] expV;
        logic [8:0] obsV;
        int         n;
        n = 0;
        while (expQ.size() > 0) begin
            expV = expQ.pop_front();
            checks++;
            if (obsQ.size() == 0) begin
                errors++;
                $display("FAIL commit_missing[%0d]: got none expected inst=%h cycle=%b", n, expV[8:1], expV[0]);
            end else begin
                obsV = obsQ.pop_front();
                if (obsV !== expV) begin
                    errors++;
                    $display("FAIL commit[%0d]: got inst=%h cycle=%b expected inst=%h cycle=%b",
                             n, obsV[8:1], obsV[0], expV[8:1], expV[0]);
                end else begin
                    $display("txn %0d: commit inst=%h cycle=%b ok", n, obsV[8:1], obsV[0]);
                end
            end
            n++;
        end
        checks++;
        if (obsQ.size() != 0) begin
            errors++;
            $display("FAIL commit_extra: got %0d unexpected commits expected 0", obsQ.size());
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        inst_in    = 8'h00;
        inst_valid = 1'b0;
        mem_ready  = 1'b0;
        irq        = 1'b0;
        cli        = 1'b0;
        halt_req   = 1'b0;
        test_reset();
        test_single();
        test_mem_stall();
        test_jump();
        test_interrupt();
        test_halt();
        test_reset_mid_stall();
        test_scoreboard();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
